ff_rs_force_arb: RTL and testbench

//  Arbitrates asynchronous set/clear ("force") requests from NREQ requesters onto a bank of WIDTH
//  ff_rs-style flip-flops, whose R/S inputs are active-low and idle high (1,1 = normal clocked op).

---
 rtl/ff_rs_force_arb.sv | 202 ++++++++++++++++++++
 tb/tb_ff_rs_force_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ff_rs_force_arb.sv
// ff_rs_force_arb: round-robin arbiter that issues timed active-low set/clear pulses to a bank of ff_rs flops.
// Define FF_RS_FORCE_ARB_STATUS_EN to keep a shadow of the last forced value per flop on STATUS.
module ff_rs_force_arb #(
    parameter int WIDTH        = 8,
    parameter int NREQ         = 4,
    parameter int IDX_W        = 3,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ-1:0]         REQ_SET,
    input  logic [NREQ*IDX_W-1:0]   REQ_IDX,
    output logic [NREQ-1:0]         GNT,
    output logic                    DONE,
    output logic                    ERR,
    output logic                    BUSY,
    output logic [WIDTH-1:0]        FF_R,
    output logic [WIDTH-1:0]        FF_S,
    output logic [WIDTH-1:0]        STATUS
);
    localparam int RR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_IDLE    = 2'd1,
        S_ASSERT  = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bad_q, bad_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   ff_r_q, ff_r_d;
    logic [WIDTH-1:0]   ff_s_q, ff_s_d;

    logic [NREQ-1:0]    rot_s;
    logic               found_s;
    logic [RR_W-1:0]    pos_s, win_s, win_nxt_s;
    logic [RR_W:0]      sum_s, sum_nxt_s;
    logic               sel_set_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               sel_bad_s;
    logic [WIDTH-1:0]   sel_mask_s;

    // Round-robin pick: rotate REQ so the pointer sits at bit 0, then take the lowest set bit.
    always_comb begin
        rot_s   = NREQ'({REQ, REQ} >> rr_q);
        found_s = |rot_s;
        pos_s   = {RR_W{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            pos_s = rot_s[i] ? RR_W'(i) : pos_s;
        end
        sum_s = {1'b0, rr_q} + {1'b0, pos_s};
        if (sum_s >= (RR_W+1)'(NREQ)) begin
            win_s = RR_W'(sum_s - (RR_W+1)'(NREQ));
        end else begin
            win_s = sum_s[RR_W-1:0];
        end
        sum_nxt_s = {1'b0, win_s} + (RR_W+1)'(1'b1);
        if (sum_nxt_s >= (RR_W+1)'(NREQ)) begin
            win_nxt_s = {RR_W{1'b0}};
        end else begin
            win_nxt_s = sum_nxt_s[RR_W-1:0];
        end
        sel_set_s = 1'b0;
        sel_idx_s = {IDX_W{1'b0}};
        for (int j = 0; j < NREQ; j++) begin
            sel_set_s = (win_s == RR_W'(j)) ? REQ_SET[j] : sel_set_s;
            sel_idx_s = (win_s == RR_W'(j)) ? REQ_IDX[j*IDX_W +: IDX_W] : sel_idx_s;
        end
        sel_bad_s  = ({1'b0, sel_idx_s} >= (IDX_W+1)'(WIDTH));
        sel_mask_s = WIDTH'(1'b1) << sel_idx_s;
    end

    // Next-state and registered-output decode; REQ is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        gnt_d   = {NREQ{1'b0}};
        done_d  = 1'b0;
        err_d   = 1'b0;
        ff_r_d  = ff_r_q;
        ff_s_d  = ff_s_q;
        case (state_q)
            S_INIT: begin
                state_d = S_IDLE;
                ff_r_d  = {WIDTH{1'b1}};
                ff_s_d  = {WIDTH{1'b1}};
            end
            S_IDLE: begin
                if (found_s) begin
                    gnt_d = NREQ'(1'b1) << win_s;
                    rr_d  = win_nxt_s;
                    cnt_d = {CNT_W{1'b0}};
                    bad_d = sel_bad_s;
                    if (sel_bad_s) begin
                        state_d = S_RECOVER;
                    end else if (sel_set_s) begin
                        state_d = S_ASSERT;
                        ff_s_d  = ~sel_mask_s;
                    end else begin
                        state_d = S_ASSERT;
                        ff_r_d  = ~sel_mask_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ASSERT: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    state_d = S_RECOVER;
                    ff_r_d  = {WIDTH{1'b1}};
                    ff_s_d  = {WIDTH{1'b1}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = bad_q;
                bad_d   = 1'b0;
            end
            default: begin
                state_d = S_INIT;
                ff_r_d  = {WIDTH{1'b1}};
                ff_s_d  = {WIDTH{1'b1}};
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears the bank (R low, S high).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_INIT;
            rr_q    <= {RR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            bad_q   <= 1'b0;
            gnt_q   <= {NREQ{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            ff_r_q  <= {WIDTH{1'b0}};
            ff_s_q  <= {WIDTH{1'b1}};
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ff_r_q  <= ff_r_d;
            ff_s_q  <= ff_s_d;
        end
    end

`ifdef FF_RS_FORCE_ARB_STATUS_EN
    logic [WIDTH-1:0] status_q, status_d;

    // Shadow of the forced value, updated on the grant that enters ASSERT.
    always_comb begin
        if (state_q == S_IDLE && found_s && !sel_bad_s) begin
            status_d = (status_q & ~sel_mask_s) | (sel_set_s ? sel_mask_s : {WIDTH{1'b0}});
        end else begin
            status_d = status_q;
        end
    end

    // Shadow register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            status_q <= {WIDTH{1'b0}};
        end else begin
            status_q <= status_d;
        end
    end

    assign STATUS = status_q;
`else
    assign STATUS = {WIDTH{1'b0}};
`endif

    assign GNT  = gnt_q;
    assign DONE = done_q;
    assign ERR  = err_q;
    assign BUSY = busy_q;
    assign FF_R = ff_r_q;
    assign FF_S = ff_s_q;

endmodule

// File: tb/tb_ff_rs_force_arb.sv
// Directed bench for ff_rs_force_arb: an 8-flop instance plus a 6-flop instance sharing all inputs.
module tb_ff_rs_force_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [3:0]  req_set = 4'h0;
    logic [11:0] req_idx = 12'h000;

    logic [3:0]  gnt, w_gnt;
    logic        done, err, busy, w_done, w_err, w_busy;
    logic [7:0]  ff_r, ff_s, status;
    logic [5:0]  w_ff_r, w_ff_s, w_status;

    logic        in_init = 1'b1;
    int          checks = 0;
    int          errors = 0;

`ifdef FF_RS_FORCE_ARB_STATUS_EN
    localparam logic [7:0] ST_SET5   = 8'h20;
    localparam logic [5:0] W_ST_SET5 = 6'h20;
`else
    localparam logic [7:0] ST_SET5   = 8'h00;
    localparam logic [5:0] W_ST_SET5 = 6'h00;
`endif

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) in_init <= 1'b1;
        else     in_init <= 1'b0;
    end

    ff_rs_force_arb #(.WIDTH(8), .NREQ(4), .IDX_W(3), .PULSE_CYCLES(2)) dut (
        .CLK(clk), .RESET(rst), .REQ(req), .REQ_SET(req_set), .REQ_IDX(req_idx),
        .GNT(gnt), .DONE(done), .ERR(err), .BUSY(busy),
        .FF_R(ff_r), .FF_S(ff_s), .STATUS(status)
    );

    ff_rs_force_arb #(.WIDTH(6), .NREQ(4), .IDX_W(3), .PULSE_CYCLES(2)) dut6 (
        .CLK(clk), .RESET(rst), .REQ(req), .REQ_SET(req_set), .REQ_IDX(req_idx),
        .GNT(w_gnt), .DONE(w_done), .ERR(w_err), .BUSY(w_busy),
        .FF_R(w_ff_r), .FF_S(w_ff_s), .STATUS(w_status)
    );

    // Bank invariants: at most one force line low, never R and S low on the same flop.
    task monitor;
        forever begin
            @(negedge clk);
            if (!in_init) begin
                checks++;
                if (($countones(~ff_r) + $countones(~ff_s)) > 1 || (~ff_r & ~ff_s) != 8'h00) begin
                    errors++; $display("FAIL invariant_main: ff_r=%h ff_s=%h, required at most one low bit", ff_r, ff_s);
                end
                checks++;
                if (($countones(~w_ff_r) + $countones(~w_ff_s)) > 1 || (~w_ff_r & ~w_ff_s) != 6'h00) begin
                    errors++; $display("FAIL invariant_w6: ff_r=%h ff_s=%h, required at most one low bit", w_ff_r, w_ff_s);
                end
            end
        end
    endtask

    task do_reset;
        @(negedge clk); rst = 1'b1; req = 4'h0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task test_reset;
        @(negedge clk); #2; rst = 1'b1; #1;
        checks++; if (ff_r !== 8'h00) begin errors++; $display("FAIL reset_ff_r: got %h expected %h", ff_r, 8'h00); end
        checks++; if (ff_s !== 8'hFF) begin errors++; $display("FAIL reset_ff_s: got %h expected %h", ff_s, 8'hFF); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (gnt !== 4'h0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses: gnt=%b done=%b err=%b expected 0", gnt, done, err); end
        checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", status); end
        checks++; if (w_ff_r !== 6'h00) begin errors++; $display("FAIL reset_w6_ff_r: got %h expected 00", w_ff_r); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (ff_r !== 8'h00) begin errors++; $display("FAIL init_hold_ff_r: got %h expected 00", ff_r); end
        @(negedge clk);
        checks++; if (ff_r !== 8'hFF) begin errors++; $display("FAIL init_ff_r: got %h expected FF", ff_r); end
        checks++; if (ff_s !== 8'hFF) begin errors++; $display("FAIL init_ff_s: got %h expected FF", ff_s); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy: got %b expected 0", busy); end
        checks++; if (w_ff_r !== 6'h3F) begin errors++; $display("FAIL init_w6_ff_r: got %h expected 3F", w_ff_r); end
    endtask

    task test_single_set;
        req = 4'b0010; req_set = 4'b0010; req_idx = 12'h028;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL set_gnt: got %b expected 0010", gnt); end
        checks++; if (ff_s !== 8'hDF || ff_r !== 8'hFF) begin errors++; $display("FAIL set_lines: ff_s=%h ff_r=%h expected DF FF", ff_s, ff_r); end
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL set_busy: busy=%b done=%b expected 1 0", busy, done); end
        checks++; if (w_ff_s !== 6'h1F) begin errors++; $display("FAIL set_w6_ff_s: got %h expected 1F", w_ff_s); end
        req = 4'h0;
        @(negedge clk);
        checks++; if (gnt !== 4'h0 || ff_s !== 8'hDF) begin errors++; $display("FAIL set_hold: gnt=%b ff_s=%h expected 0000 DF", gnt, ff_s); end
        @(negedge clk);
        checks++; if (ff_s !== 8'hFF || done !== 1'b0) begin errors++; $display("FAIL set_recover: ff_s=%h done=%b expected FF 0", ff_s, done); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL set_done: done=%b err=%b busy=%b expected 1 0 0", done, err, busy); end
        checks++; if (status !== ST_SET5) begin errors++; $display("FAIL set_status: got %h expected %h", status, ST_SET5); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL set_done_pulse: got %b expected 0", done); end
    endtask

    task test_error;
        req = 4'b0001; req_set = 4'b0001; req_idx = 12'h007;
        @(negedge clk);
        checks++; if (w_gnt !== 4'b0001) begin errors++; $display("FAIL err_gnt: got %b expected 0001", w_gnt); end
        checks++; if (w_ff_r !== 6'h3F || w_ff_s !== 6'h3F) begin errors++; $display("FAIL err_no_force: ff_r=%h ff_s=%h expected 3F 3F", w_ff_r, w_ff_s); end
        checks++; if (w_busy !== 1'b1 || w_done !== 1'b0) begin errors++; $display("FAIL err_busy: busy=%b done=%b expected 1 0", w_busy, w_done); end
        checks++; if (ff_s !== 8'h7F) begin errors++; $display("FAIL top_idx_ff_s: got %h expected 7F", ff_s); end
        req = 4'h0;
        @(negedge clk);
        checks++; if (w_done !== 1'b1 || w_err !== 1'b1) begin errors++; $display("FAIL err_done: done=%b err=%b expected 1 1", w_done, w_err); end
        checks++; if (w_status !== W_ST_SET5) begin errors++; $display("FAIL err_status: got %h expected %h", w_status, W_ST_SET5); end
        @(negedge clk);
        checks++; if (w_done !== 1'b0 || w_err !== 1'b0 || w_busy !== 1'b0) begin errors++; $display("FAIL err_after: done=%b err=%b busy=%b expected 0 0 0", w_done, w_err, w_busy); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL top_idx_done: done=%b err=%b expected 1 0", done, err); end
    endtask

    task test_round_robin;
        logic [3:0] exp_g;
        logic [7:0] exp_r;
        do_reset();
        req = 4'hF; req_set = 4'h0; req_idx = 12'h688;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            exp_r = ~(8'h01 << (g % 4));
            @(negedge clk);
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", g, gnt, exp_g); end
            checks++; if (ff_r !== exp_r || ff_s !== 8'hFF) begin errors++; $display("FAIL rr_lines%0d: ff_r=%h ff_s=%h expected %h FF", g, ff_r, ff_s, exp_r); end
            checks++; if (w_gnt !== exp_g) begin errors++; $display("FAIL rr_w6_gnt%0d: got %b expected %b", g, w_gnt, exp_g); end
            if (g == 4) req = 4'h0;
            @(negedge clk);
            checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL rr_gnt_pulse%0d: got %b expected 0000", g, gnt); end
            @(negedge clk);
            @(negedge clk);
            checks++; if (done !== 1'b1 || gnt !== 4'h0) begin errors++; $display("FAIL rr_done%0d: done=%b gnt=%b expected 1 0000", g, done, gnt); end
        end
    endtask

    task test_reset_mid_op;
        req = 4'b0100; req_set = 4'b0100; req_idx = 12'h080;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100 || ff_s !== 8'hFB) begin errors++; $display("FAIL abort_setup: gnt=%b ff_s=%h expected 0100 FB", gnt, ff_s); end
        req = 4'h0;
        @(negedge clk); #2; rst = 1'b1; #1;
        checks++; if (ff_s !== 8'hFF || ff_r !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL abort_async: ff_s=%h ff_r=%h busy=%b expected FF 00 1", ff_s, ff_r, busy); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || ff_r !== 8'hFF) begin errors++; $display("FAIL abort_no_done: done=%b busy=%b ff_r=%h expected 0 0 FF", done, busy, ff_r); end
        req = 4'hF; req_set = 4'h0; req_idx = 12'h688;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001 || ff_r !== 8'hFE) begin errors++; $display("FAIL abort_rr_zero: gnt=%b ff_r=%h expected 0001 FE", gnt, ff_r); end
        req = 4'h0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_next_done: got %b expected 1", done); end
    endtask

    task test_busy_pulse;
        req = 4'b0001; req_set = 4'b0000; req_idx = 12'h001;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001 || ff_r !== 8'hFD) begin errors++; $display("FAIL busy_setup: gnt=%b ff_r=%h expected 0001 FD", gnt, ff_r); end
        req = 4'h0;
        @(negedge clk);
        req = 4'b1000;
        checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL busy_gnt_a: got %b expected 0000", gnt); end
        @(negedge clk);
        req = 4'h0;
        checks++; if (gnt !== 4'h0 || ff_r !== 8'hFF) begin errors++; $display("FAIL busy_gnt_b: gnt=%b ff_r=%h expected 0000 FF", gnt, ff_r); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || gnt !== 4'h0) begin errors++; $display("FAIL busy_done: done=%b gnt=%b expected 1 0000", done, gnt); end
        @(negedge clk);
        checks++; if (gnt !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL busy_ignored: gnt=%b busy=%b expected 0000 0", gnt, busy); end
        #1; req = 4'b0010; #2; req = 4'h0;
        @(negedge clk);
        checks++; if (gnt !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL withdraw: gnt=%b busy=%b expected 0000 0", gnt, busy); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_set();
        test_error();
        test_round_robin();
        test_reset_mid_op();
        test_busy_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
